// File: rtl/tdm_demux_pkg.sv
// Shared types and sizes for the 1-to-4 TDM demultiplexer.
//   LANES       : number of TDM lanes per frame
//   SLOT_W      : width of the slot counter
//   tdm_state_t : receive state (IDLE waits for SOF, COLLECT fills lanes)
package tdm_demux_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned SLOT_W = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } tdm_state_t;

endpackage : tdm_demux_pkg

// File: rtl/demux_1to4.sv
// Combinational 2-to-4 one-hot decoder: turns the target slot and the
// write strobe into per-lane write enables (inverse of mux_4to1).
//   sel      : lane index to write
//   en       : write strobe
//   lane_we_c: one-hot lane write enables (all zero when en=0)
module demux_1to4
    import tdm_demux_pkg::*;
(
    input  logic [SLOT_W-1:0] sel,
    input  logic              en,
    output logic [LANES-1:0]  lane_we_c
);

    always_comb begin
        lane_we_c      = '0;
        lane_we_c[sel] = en;
    end

endmodule : demux_1to4

// File: rtl/tdm_demux_1to4.sv
// Time-division 1-to-4 demultiplexer. Steers a serial word stream (lanes
// 0..3 in turn, slot 0 marked by in_sof) into lane registers and presents
// each completed frame as one parallel word under valid/ready.
//   clk, rst_n : clock, synchronous active-low reset
//   in_data    : serial word           in_valid : word/sof valid
//   in_sof     : word is slot 0        in_ready : word can be accepted (comb)
//   out_data   : frame, lane k at [k*WIDTH +: WIDTH]
//   out_valid  : frame held            out_ready: consumer takes frame
//   frame_err  : one-cycle pulse on a partial frame aborted by early SOF
//   slot       : next slot to be written
module tdm_demux_1to4
    import tdm_demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    input  logic                   in_sof,
    output logic                   in_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   frame_err,
    output logic [SLOT_W-1:0]      slot
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LANES - 1);

    tdm_state_t                    state_q, state_d;
    logic [SLOT_W-1:0]             slot_q, slot_d;
    logic [LANES-1:0][WIDTH-1:0]   lane_q, lane_d;
    logic [LANES*WIDTH-1:0]        out_data_q, out_data_d;
    logic                          out_valid_q, out_valid_d;
    logic                          frame_err_q, frame_err_d;

    logic                          accept_c;
    logic                          wr_en_c;
    logic [SLOT_W-1:0]             wr_sel_c;
    logic [LANES-1:0]              lane_we_c;

    // Only the completing word stalls, and only while an older frame is held.
    assign in_ready = !(state_q == COLLECT && slot_q == LAST_SLOT &&
                        out_valid_q && !out_ready);
    assign accept_c = in_valid && in_ready;

    // SOF always targets lane 0; in IDLE only SOF words are stored.
    assign wr_sel_c = in_sof ? '0 : slot_q;
    assign wr_en_c  = accept_c && (state_q == COLLECT || in_sof);

    demux_1to4 u_lane_dec (
        .sel       (wr_sel_c),
        .en        (wr_en_c),
        .lane_we_c (lane_we_c)
    );

    // Next-state, lane write and output-register logic.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        frame_err_d = 1'b0;

        for (int k = 0; k < int'(LANES); k++) begin
            lane_d[k] = lane_we_c[k] ? in_data : lane_q[k];
        end

        case (state_q)
            IDLE: begin
                if (accept_c && in_sof) begin
                    slot_d  = SLOT_W'(1);
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (accept_c) begin
                    if (in_sof && slot_q != '0) begin
                        slot_d      = SLOT_W'(1);
                        frame_err_d = 1'b1;
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                        // A completing frame may overwrite one handed off this cycle.
                        if (slot_q == LAST_SLOT) begin
                            out_data_d  = {in_data, lane_q[LANES-2:0]};
                            out_valid_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            lane_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            lane_q      <= lane_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign slot      = slot_q;

endmodule : tdm_demux_1to4
